muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the two operands read from the register file, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and drives the register-file write port (`reg_write`, `write_reg`, `write_data`) with a one-cycle write pulse when the result is ready. The core stalls on `busy` while an operation is in flight.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply and restoring divide.
// Optional macro MULDIV_FASTPATH_EN lets trivial cases (x/0, overflow, mul by 0) skip CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t            state, state_nx;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   op_a, op_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [5:0]        cnt;
  logic              neg_q, rem_neg, divz, ovf, mzero;

  logic              s1_sgn, s2_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              in_divz, in_ovf, in_mzero, accept;
  logic              busy_nx, done_nx, reg_write_nx;

  always_comb begin
    s1_sgn   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    s2_sgn   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    a_neg    = s1_sgn && rs1_data[XLEN-1];
    b_neg    = s2_sgn && rs2_data[XLEN-1];
    abs_a    = neg_word(rs1_data, a_neg);
    abs_b    = neg_word(rs2_data, b_neg);
    in_divz  = funct3[2] && (rs2_data == '0);
    in_ovf   = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == '1);
    in_mzero = !funct3[2] && ((rs1_data == '0) || (rs2_data == '0));
    accept   = (state == IDLE) && start && !kill;
  end

`ifdef MULDIV_FASTPATH_EN
  wire fast_hit = in_divz || in_ovf || in_mzero;
`else
  wire fast_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fast_hit ? DONE : CALC;
      CALC:    if (kill) state_nx = IDLE;
               else if (cnt == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state == DONE) && !kill;
    reg_write_nx = done_nx && (rd_q != 5'd0);
  end

  // Iteration step: shift-add multiply, restoring divide
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_shift, div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_a} : '0);
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = div_shift - {2'b00, op_b};
    div_ge    = !div_diff[XLEN+1];
  end

  // Result select with sign correction and forced special cases
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quot_c, rem_c, result;

  always_comb begin
    prod_c = neg_dword(acc, neg_q);
    quot_c = neg_word(acc[XLEN-1:0], neg_q);
    rem_c  = neg_word(divz ? op_a : rem[XLEN-1:0], rem_neg);
    case (f3_q)
      3'b000:                 result = mzero ? '0 : prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = mzero ? '0 : prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = divz ? '1 :
                                       ovf  ? {1'b1, {(XLEN-1){1'b0}}} : quot_c;
      default:                result = ovf ? '0 : rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      busy      <= busy_nx;
      done      <= done_nx;
      reg_write <= reg_write_nx;
      if (done_nx) begin
        write_reg  <= rd_q;
        write_data <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= '0;
      rd_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      rem_neg <= 1'b0;
      divz    <= 1'b0;
      ovf     <= 1'b0;
      mzero   <= 1'b0;
    end else if (accept) begin
      f3_q    <= funct3;
      rd_q    <= rd;
      op_a    <= abs_a;
      op_b    <= abs_b;
      acc     <= {{XLEN{1'b0}}, funct3[2] ? abs_a : abs_b};
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= a_neg ^ b_neg;
      rem_neg <= a_neg;
      divz    <= in_divz;
      ovf     <= in_ovf;
      mzero   <= in_mzero;
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      if (f3_q[2]) begin
        rem             <= div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
        acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ge};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus random ops against
// an arithmetic reference model; latency expectation follows MULDIV_FASTPATH_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_chk = 0;
  int n_fail = 0;

`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .kill(kill),
    .busy(busy), .done(done), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    longint      sprod, suprod;
    logic [63:0] uprod;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    ub     = {32'd0, b};
    sprod  = sa * sb;
    suprod = sa * ub;
    uprod  = {32'd0, a} * {32'd0, b};
    case (f3)
      3'd0: return uprod[31:0];
      3'd1: return sprod[63:32];
      3'd2: return suprod[63:32];
      3'd3: return uprod[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_trivial(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && b == 0) return 1'b1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    if (!f3[2] && (a == 0 || b == 0)) return 1'b1;
    return 1'b0;
  endfunction

  // Called just after the accepting edge; returns at the cycle where done is high.
  task automatic wait_done(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rdv,
                           input logic [31:0] exp);
    int k;
    int exp_k;
    exp_k = (FAST && is_trivial(f3, a, b)) ? 1 : 33;
    k = 0;
    @(negedge clk);
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_done_early"}, done, 0);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, exp_k);
    chk({tag, "_data"}, write_data, exp);
    chk({tag, "_wreg"}, write_reg, rdv);
    chk({tag, "_rw"}, reg_write, (rdv != 0));
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rdv,
                        input logic [31:0] exp);
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; rd = rdv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
    wait_done(tag, f3, a, b, rdv, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {done, reg_write}, 2'b00);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || reg_write) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  r;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rw", reg_write, 0);
    chk("rst_wreg", write_reg, 0);
    chk("rst_wdata", write_data, 0);
    rst_n = 1'b1;

    run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFF);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
    run_op("divu",   3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
    run_op("remu",   3'd7, 32'd100, 32'd7, 5'd12, 32'd2);
    run_op("div0",   3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
    run_op("rem0",   3'd6, 32'd5, 32'd0, 5'd14, 32'd5);
    run_op("remneg0",3'd6, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFF9);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
    run_op("mulz",   3'd1, 32'd0, 32'hFFFF_FFFD, 5'd17, 32'd0);

    // rd=0 with start held through busy, then a second op taken right after done
    @(negedge clk);
    funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd = 5'd0; start = 1'b1;
    @(posedge clk);
    #1 funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd18;
    wait_done("hold_rd0", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0, 32'hFFFF_FFEB);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("hold_next", 3'd5, 32'd100, 32'd7, 5'd18, 32'd14);

    // kill ten cycles into CALC
    @(negedge clk);
    funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", busy, 0);
    watch_quiet("kill_quiet", 40);

    // kill and start together in IDLE
    @(negedge clk);
    funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd = 5'd4; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("killstart_busy", busy, 0);
    watch_quiet("killstart_quiet", 40);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rw", reg_write, 0);
    chk("arst_wreg", write_reg, 0);
    chk("arst_wdata", write_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("arst_quiet", 40);
    run_op("after_rst", 3'd4, 32'd1000, 32'd3, 5'd21, 32'd333);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      r  = 5'($urandom);
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, r, ref_res(f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
